// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note-code to Hz table,
// FSM state encoding, song ROM entry layout and a default demo song.
package melody_pkg;

   localparam int NOTE_W  = 5;
   localparam int DUR_W   = 3;
   localparam int ENTRY_W = NOTE_W + DUR_W;
   localparam int HZ_W    = 12;

   localparam logic [DUR_W-1:0] END_DUR = '0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_NOTE,
      ST_GAP,
      ST_PAUSE
   } state_t;

   // Entry 0 sits in the low byte: C4, E4, G4 (2 units each), C5 (4 units), end.
   localparam logic [255:0] DEFAULT_SONG = {216'h0, 8'h00, 8'h44, 8'h2A, 8'h1A, 8'h0A};

   function automatic logic [HZ_W-1:0] note_hz(input logic [NOTE_W-1:0] code);
      logic [HZ_W-1:0] hz;
      hz = '0;
      case (code)
         5'd1:  hz = 12'd262;
         5'd2:  hz = 12'd294;
         5'd3:  hz = 12'd330;
         5'd4:  hz = 12'd349;
         5'd5:  hz = 12'd392;
         5'd6:  hz = 12'd440;
         5'd7:  hz = 12'd494;
         5'd8:  hz = 12'd523;
         5'd9:  hz = 12'd587;
         5'd10: hz = 12'd659;
         5'd11: hz = 12'd698;
         5'd12: hz = 12'd784;
         5'd13: hz = 12'd880;
         5'd14: hz = 12'd988;
         5'd15: hz = 12'd1047;
         5'd16: hz = 12'd1175;
         5'd17: hz = 12'd1319;
         5'd18: hz = 12'd1397;
         5'd19: hz = 12'd1568;
         5'd20: hz = 12'd1760;
         5'd21: hz = 12'd1976;
         default: hz = '0;
      endcase
      return hz;
   endfunction

endpackage

// File: rtl/song_rom.sv
// Song storage: one {note, duration} byte per address, registered read.
// Contents come from the SONG parameter so each song is a drop-in replacement.
module song_rom import melody_pkg::*; #(
   parameter int ADDR_W = 5,
   parameter logic [ENTRY_W*(2**ADDR_W)-1:0] SONG = '0
) (
   input  logic               clk,
   input  logic [ADDR_W-1:0]  addr,
   output logic [ENTRY_W-1:0] data
);

   always_ff @(posedge clk) begin
      data <= SONG[{addr, 3'b000} +: ENTRY_W];
   end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM and drives a held tone frequency for the buzzer,
// with a silent gap at the end of every note and play/pause/stop/loop control.
module melody_sequencer import melody_pkg::*; #(
   parameter int unsigned TICKS_PER_UNIT = 12_500_000,
   parameter int unsigned GAP_TICKS      = 5_000_000,
   parameter int          ADDR_W         = 5,
   parameter logic [ENTRY_W*(2**ADDR_W)-1:0] SONG = DEFAULT_SONG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              play,
   input  logic              pause,
   input  logic              stop,
   input  logic              loop_en,
   output logic [HZ_W-1:0]   hz_next,
   output logic [ADDR_W-1:0] note_addr,
   output logic              playing,
   output logic              paused,
   output logic              song_done
);

   state_t             state_q, state_d;
   state_t             saved_state_q, saved_state_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [HZ_W-1:0]    hz_q, hz_d;
   logic [HZ_W-1:0]    saved_hz_q, saved_hz_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               done_q, done_d;

   logic [ENTRY_W-1:0] rom_data;
   logic [NOTE_W-1:0]  rom_code;
   logic [DUR_W-1:0]   rom_dur;
   logic [31:0]        note_cnt;

   // The ROM is addressed with the next address so the entry is ready during LOAD.
   song_rom #(
      .ADDR_W (ADDR_W),
      .SONG   (SONG)
   ) u_rom (
      .clk  (clk),
      .addr (addr_d),
      .data (rom_data)
   );

   assign rom_code = rom_data[ENTRY_W-1:DUR_W];
   assign rom_dur  = rom_data[DUR_W-1:0];
   assign note_cnt = 32'(rom_dur) * TICKS_PER_UNIT - GAP_TICKS - 32'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         saved_state_q <= ST_IDLE;
         cnt_q         <= '0;
         hz_q          <= '0;
         saved_hz_q    <= '0;
         addr_q        <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         saved_state_q <= saved_state_d;
         cnt_q         <= cnt_d;
         hz_q          <= hz_d;
         saved_hz_q    <= saved_hz_d;
         addr_q        <= addr_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      saved_state_d = saved_state_q;
      cnt_d         = cnt_q;
      hz_d          = hz_q;
      saved_hz_d    = saved_hz_q;
      addr_d        = addr_q;
      done_d        = 1'b0;

      if (stop) begin
         state_d = ST_IDLE;
         hz_d    = '0;
         addr_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (play) begin
                  addr_d  = '0;
                  state_d = ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (rom_dur == END_DUR) begin
                  if (loop_en) begin
                     addr_d = '0;
                  end else begin
                     done_d  = 1'b1;
                     hz_d    = '0;
                     state_d = ST_IDLE;
                  end
               end else begin
                  hz_d    = note_hz(rom_code);
                  cnt_d   = note_cnt;
                  state_d = ST_NOTE;
               end
            end
            ST_NOTE, ST_GAP: begin
               if (pause) begin
                  saved_state_d = state_q;
                  saved_hz_d    = hz_q;
                  hz_d          = '0;
                  state_d       = ST_PAUSE;
               end else if (cnt_q == '0) begin
                  if (state_q == ST_NOTE) begin
                     hz_d    = '0;
                     cnt_d   = GAP_TICKS - 32'd1;
                     state_d = ST_GAP;
                  end else begin
                     addr_d  = addr_q + ADDR_W'(1);
                     state_d = ST_LOAD;
                  end
               end else begin
                  cnt_d = cnt_q - 32'd1;
               end
            end
            ST_PAUSE: begin
               // Resume exactly where we left off; the counter was never touched.
               if (play) begin
                  state_d = saved_state_q;
                  hz_d    = saved_hz_q;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign hz_next   = hz_q;
   assign note_addr = addr_q;
   assign playing   = (state_q == ST_LOAD) || (state_q == ST_NOTE) || (state_q == ST_GAP);
   assign paused    = (state_q == ST_PAUSE);
   assign song_done = done_q;

endmodule
